// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between N producers, the round-robin arbiter and the FIFO slave port.
interface fifo_wr_arbiter_if #(
    parameter int N    = 4,
    parameter int SIZE = 32,
    parameter int IDW  = $clog2(N)
);
    logic [N-1:0]      s_valid;
    logic [N-1:0]      s_ready;
    logic [N*SIZE-1:0] s_data;
    logic [N-1:0]      s_last;
    logic              m_valid;
    logic              m_ready;
    logic [SIZE-1:0]   m_data;
    logic [IDW-1:0]    m_src;
    logic              m_last;
    logic [N-1:0]      grant;

    // Environment side: producers drive s_*, the FIFO drives m_ready.
    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_src, m_last, grant
    );

    // Arbiter side.
    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_src, m_last, grant
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between N producers.
// A grant is locked for a burst (s_last or MAXBURST beats); data passes through combinationally.
module fifo_wr_arbiter #(
    parameter int N        = 4,
    parameter int SIZE     = 32,
    parameter int MAXBURST = 4,
    parameter int IDW      = $clog2(N),
    parameter int CNTW     = $clog2(MAXBURST + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    fifo_wr_arbiter_if.slave bus
);
    typedef enum logic {ARB, LOCK} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  src_q, src_d;
    logic [CNTW-1:0] beat_cnt_q, beat_cnt_d;

    logic [N-1:0]    rot;
    logic [IDW-1:0]  pick;
    logic            pick_vld;
    logic            g_vld;
    logic            g_last;
    logic [SIZE-1:0] g_data;
    logic            m_valid;
    logic            m_last;
    logic [SIZE-1:0] m_data;
    logic [N-1:0]    s_ready;

    // Rotate requests so bit 0 is the rr_ptr position, then take the lowest set bit.
    always_comb begin
        logic [IDW:0] sum;
        rot      = N'({bus.s_valid, bus.s_valid} >> rr_ptr_q);
        pick     = '0;
        pick_vld = 1'b0;
        sum      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
                if (sum >= (IDW+1)'(N)) sum = sum - (IDW+1)'(N);
                pick     = IDW'(sum);
                pick_vld = 1'b1;
            end
        end
    end

    // Select the granted producer's valid/last/data without variable-width indexing.
    always_comb begin
        g_vld  = 1'b0;
        g_last = 1'b0;
        g_data = '0;
        for (int k = 0; k < N; k++) begin
            if (src_q == IDW'(k)) begin
                g_vld  = bus.s_valid[k];
                g_last = bus.s_last[k];
                g_data = bus.s_data[k*SIZE +: SIZE];
            end
        end
    end

    // Next-state and pass-through outputs; ARB keeps the FIFO port quiet.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        src_d      = src_q;
        beat_cnt_d = beat_cnt_q;
        m_valid    = 1'b0;
        m_last     = 1'b0;
        m_data     = '0;
        s_ready    = '0;
        case (state_q)
            ARB: begin
                if (pick_vld) begin
                    grant_d    = N'(1) << pick;
                    src_d      = pick;
                    beat_cnt_d = '0;
                    state_d    = LOCK;
                end
            end
            LOCK: begin
                m_valid = g_vld;
                m_data  = g_data;
                m_last  = g_last | (beat_cnt_q == CNTW'(MAXBURST - 1));
                s_ready = grant_q & {N{bus.m_ready}};
                if (m_valid && bus.m_ready) begin
                    beat_cnt_d = beat_cnt_q + CNTW'(1);
                    if (m_last) begin
                        // The producer just served drops to lowest priority.
                        rr_ptr_d = (src_q == IDW'(N - 1)) ? '0 : src_q + IDW'(1);
                        grant_d  = '0;
                        state_d  = ARB;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    // State registers; asynchronous reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ARB;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            src_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            src_q      <= src_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign bus.m_valid = m_valid;
    assign bus.m_data  = m_data;
    assign bus.m_last  = m_last;
    assign bus.m_src   = src_q;
    assign bus.s_ready = s_ready;
    assign bus.grant   = grant_q;
endmodule
